// File: rtl/clock_pkg.sv
// Shared time-of-day types and limits for the clock blocks.
// The alarm and date blocks reuse time_t and the wrap helpers.
package clock_pkg;

   localparam int HOUR_W   = 5;
   localparam int MINSEC_W = 6;

   localparam logic [MINSEC_W-1:0] SEC_MAX  = 6'd59;
   localparam logic [MINSEC_W-1:0] MIN_MAX  = 6'd59;
   localparam logic [HOUR_W-1:0]   HOUR_MAX = 5'd23;

   typedef struct packed {
      logic [HOUR_W-1:0]   hours;
      logic [MINSEC_W-1:0] mins;
      logic [MINSEC_W-1:0] secs;
   } time_t;

   // Saturating compare keeps a corrupted value from ever walking past max.
   function automatic logic [MINSEC_W-1:0] wrap_inc_ms(input logic [MINSEC_W-1:0] v,
                                                       input logic [MINSEC_W-1:0] max);
      return (v >= max) ? {MINSEC_W{1'b0}} : v + 6'd1;
   endfunction

   function automatic logic [HOUR_W-1:0] wrap_inc_h(input logic [HOUR_W-1:0] v);
      return (v >= HOUR_MAX) ? {HOUR_W{1'b0}} : v + 5'd1;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICKS_PER_SEC enabled cycles.
module tick_prescaler #(
   parameter int TICKS_PER_SEC = 100_000_000,
   parameter int PRESCALE_W    = $clog2(TICKS_PER_SEC)
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam logic [PRESCALE_W-1:0] TERM = PRESCALE_W'(TICKS_PER_SEC - 1);

   logic [PRESCALE_W-1:0] pcnt;

   assign tick = en && (pcnt == TERM);

   // clr wins over counting so a load restarts a full second
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pcnt <= {PRESCALE_W{1'b0}};
      end else if (clr) begin
         pcnt <= {PRESCALE_W{1'b0}};
      end else if (tick) begin
         pcnt <= {PRESCALE_W{1'b0}};
      end else if (en) begin
         pcnt <= pcnt + PRESCALE_W'(1);
      end else begin
         pcnt <= pcnt;
      end
   end

endmodule

// File: rtl/rtc_timekeeper.sv
// Time-of-day core: 1 Hz seconds/minutes/hours with load, increment buttons,
// 12/24 h display mapping and carry pulses for the alarm and date blocks.
module rtc_timekeeper
   import clock_pkg::*;
#(
   parameter int TICKS_PER_SEC = 100_000_000,
   parameter int PRESCALE_W    = $clog2(TICKS_PER_SEC)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                run,
   input  logic                mode_12h,
   input  logic                set_en,
   input  logic [HOUR_W-1:0]   set_hours,
   input  logic [MINSEC_W-1:0] set_mins,
   input  logic                inc_hour,
   input  logic                inc_min,
   output logic [HOUR_W-1:0]   hours,
   output logic [MINSEC_W-1:0] mins,
   output logic [MINSEC_W-1:0] secs,
   output logic [HOUR_W-1:0]   disp_hours,
   output logic                pm,
   output logic                sec_pulse,
   output logic                min_carry,
   output logic                day_carry,
   output logic                set_err
);

   time_t cur, nxt;
   logic  tick, load_ok, load;
   logic  sec_pulse_nxt, min_carry_nxt, day_carry_nxt, set_err_nxt;

   assign load_ok = (set_hours <= HOUR_MAX) && (set_mins <= MIN_MAX);
   assign load    = set_en && load_ok;

   tick_prescaler #(
      .TICKS_PER_SEC (TICKS_PER_SEC),
      .PRESCALE_W    (PRESCALE_W)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .en    (run),
      .clr   (load),
      .tick  (tick)
   );

   // Priority: load strobe, then increment buttons, then the 1 Hz tick.
   always_comb begin
      nxt           = cur;
      sec_pulse_nxt = 1'b0;
      min_carry_nxt = 1'b0;
      day_carry_nxt = 1'b0;
      set_err_nxt   = 1'b0;
      if (set_en) begin
         if (load_ok) begin
            nxt.hours = set_hours;
            nxt.mins  = set_mins;
            nxt.secs  = 6'd0;
         end else begin
            set_err_nxt = 1'b1;
         end
      end else if (inc_hour || inc_min) begin
         if (inc_hour) begin
            nxt.hours = wrap_inc_h(cur.hours);
         end else begin
            nxt.hours = cur.hours;
         end
         if (inc_min) begin
            nxt.mins = wrap_inc_ms(cur.mins, MIN_MAX);
         end else begin
            nxt.mins = cur.mins;
         end
      end else if (tick) begin
         sec_pulse_nxt = 1'b1;
         nxt.secs      = wrap_inc_ms(cur.secs, SEC_MAX);
         if (cur.secs >= SEC_MAX) begin
            min_carry_nxt = 1'b1;
            nxt.mins      = wrap_inc_ms(cur.mins, MIN_MAX);
            if (cur.mins >= MIN_MAX) begin
               nxt.hours     = wrap_inc_h(cur.hours);
               day_carry_nxt = (cur.hours >= HOUR_MAX);
            end else begin
               nxt.hours = cur.hours;
            end
         end else begin
            nxt.mins = cur.mins;
         end
      end else begin
         nxt = cur;
      end
   end

   // Time and pulses update together so pulses align with the new value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur       <= '0;
         sec_pulse <= 1'b0;
         min_carry <= 1'b0;
         day_carry <= 1'b0;
         set_err   <= 1'b0;
      end else begin
         cur       <= nxt;
         sec_pulse <= sec_pulse_nxt;
         min_carry <= min_carry_nxt;
         day_carry <= day_carry_nxt;
         set_err   <= set_err_nxt;
      end
   end

   assign hours = cur.hours;
   assign mins  = cur.mins;
   assign secs  = cur.secs;
   assign pm    = (cur.hours >= 5'd12);

   // 12 h mapping: midnight reads 12, afternoon hours fold down by 12.
   always_comb begin
      disp_hours = cur.hours;
      if (!mode_12h) begin
         disp_hours = cur.hours;
      end else if (cur.hours == 5'd0) begin
         disp_hours = 5'd12;
      end else if (cur.hours > 5'd12) begin
         disp_hours = cur.hours - 5'd12;
      end else begin
         disp_hours = cur.hours;
      end
   end

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Scoreboard bench for rtc_timekeeper with TICKS_PER_SEC=4.
module tb_rtc_timekeeper;

   localparam int TPS = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       run = 1'b0;
   logic       mode_12h = 1'b0;
   logic       set_en = 1'b0;
   logic [4:0] set_hours = 5'd0;
   logic [5:0] set_mins = 6'd0;
   logic       inc_hour = 1'b0;
   logic       inc_min = 1'b0;
   logic [4:0] hours;
   logic [5:0] mins;
   logic [5:0] secs;
   logic [4:0] disp_hours;
   logic       pm;
   logic       sec_pulse;
   logic       min_carry;
   logic       day_carry;
   logic       set_err;

   int checks = 0;
   int failures = 0;
   int n_sp, n_mc, n_dc;
   int m_p, m_h, m_m, m_s;
   logic [26:0] exp_q[$];

   rtc_timekeeper #(.TICKS_PER_SEC(TPS)) dut (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
      .mode_12h   (mode_12h),
      .set_en     (set_en),
      .set_hours  (set_hours),
      .set_mins   (set_mins),
      .inc_hour   (inc_hour),
      .inc_min    (inc_min),
      .hours      (hours),
      .mins       (mins),
      .secs       (secs),
      .disp_hours (disp_hours),
      .pm         (pm),
      .sec_pulse  (sec_pulse),
      .min_carry  (min_carry),
      .day_carry  (day_carry),
      .set_err    (set_err)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [26:0] observed();
      return {hours, mins, secs, sec_pulse, min_carry, day_carry, set_err, disp_hours, pm};
   endfunction

   // Reference model: advance one cycle from current inputs, queue expectation.
   task automatic model_step();
      bit tick, ok, sp, mc, dc, se;
      int disp;
      tick = run && (m_p == TPS - 1);
      ok = (set_hours <= 5'd23) && (set_mins <= 6'd59);
      sp = 0; mc = 0; dc = 0; se = 0;
      if (set_en && ok) m_p = 0;
      else if (run) m_p = tick ? 0 : m_p + 1;
      if (set_en) begin
         if (ok) begin
            m_h = set_hours; m_m = set_mins; m_s = 0;
         end else se = 1;
      end else if (inc_hour || inc_min) begin
         if (inc_hour) m_h = (m_h + 1) % 24;
         if (inc_min) m_m = (m_m + 1) % 60;
      end else if (tick) begin
         sp = 1;
         m_s++;
         if (m_s == 60) begin
            m_s = 0; mc = 1; m_m++;
            if (m_m == 60) begin
               m_m = 0; m_h++;
               if (m_h == 24) begin
                  m_h = 0; dc = 1;
               end
            end
         end
      end
      disp = mode_12h ? ((m_h + 11) % 12) + 1 : m_h;
      exp_q.push_back({5'(m_h), 6'(m_m), 6'(m_s), sp, mc, dc, se, 5'(disp), (m_h >= 12)});
   endtask

   task automatic step();
      logic [26:0] e;
      model_step();
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check_value("sb_empty", 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         check_value("cycle", observed(), e);
      end
      if (sec_pulse) n_sp++;
      if (min_carry) n_mc++;
      if (day_carry) n_dc++;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      run = 1'b0; set_en = 1'b0; inc_hour = 1'b0; inc_min = 1'b0; mode_12h = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      m_p = 0; m_h = 0; m_m = 0; m_s = 0;
      exp_q.delete();
   endtask

   task automatic load(input int h, input int m);
      set_en = 1'b1; set_hours = 5'(h); set_mins = 6'(m);
      step();
      set_en = 1'b0;
   endtask

   initial begin
      int hv[4] = '{0, 12, 13, 23};
      int dv[4] = '{12, 12, 1, 11};
      int pv[4] = '{0, 1, 1, 1};

      // 1: reset and free-run one minute
      #2;
      mode_12h = 1'b1;
      #1;
      check_value("reset_disp12", disp_hours, 32'd12);
      do_reset();
      check_value("reset_state", observed(), 32'd0);
      n_sp = 0; n_mc = 0; n_dc = 0;
      run = 1'b1;
      repeat (TPS * 60) step();
      check_value("s1_pulses", n_sp, 32'd60);
      check_value("s1_mincarry", n_mc, 32'd1);
      check_value("s1_time", {hours, mins, secs}, {5'd0, 6'd1, 6'd0});

      // 2: day wrap
      load(23, 59);
      n_sp = 0; n_mc = 0; n_dc = 0;
      repeat (TPS * 60) begin
         step();
         if (day_carry) begin
            check_value("wrap_time", {hours, mins, secs}, 32'd0);
            check_value("wrap_pulses", {sec_pulse, min_carry}, 32'd3);
         end
      end
      check_value("s2_daycarry", n_dc, 32'd1);
      check_value("s2_time", {hours, mins, secs}, 32'd0);

      // 3: 12 h display
      run = 1'b0;
      mode_12h = 1'b1;
      for (int i = 0; i < 4; i++) begin
         load(hv[i], 0);
         check_value("disp12", {disp_hours, pm}, {5'(dv[i]), 1'(pv[i])});
      end

      // 4: rejected loads, one coinciding with a tick
      mode_12h = 1'b0;
      run = 1'b1;
      repeat (10) step();
      check_value("s4_pre", {hours, mins, secs}, {5'd23, 6'd0, 6'd2});
      load(24, 10);
      check_value("s4_err1", set_err, 32'd1);
      check_value("s4_hold1", {hours, mins, secs}, {5'd23, 6'd0, 6'd2});
      load(10, 60);
      check_value("s4_err2", set_err, 32'd1);
      check_value("s4_hold2", {hours, mins, secs}, {5'd23, 6'd0, 6'd2});
      load(10, 59);
      check_value("s4_load", {hours, mins, secs, set_err}, {5'd10, 6'd59, 6'd0, 1'b0});

      // 5: both increments on a tick cycle
      load(22, 59);
      repeat (TPS * 30 + 3) step();
      check_value("s5_pre", {hours, mins, secs}, {5'd22, 6'd59, 6'd30});
      inc_hour = 1'b1; inc_min = 1'b1;
      step();
      inc_hour = 1'b0; inc_min = 1'b0;
      check_value("s5_inc", {hours, mins, secs}, {5'd23, 6'd0, 6'd30});
      check_value("s5_nopulse", {sec_pulse, min_carry, day_carry}, 32'd0);

      // 6: pause, then asynchronous reset while a pulse is pending
      run = 1'b0;
      n_sp = 0; n_mc = 0; n_dc = 0;
      repeat (20) step();
      check_value("s6_pulses", n_sp + n_mc + n_dc, 32'd0);
      check_value("s6_frozen", {hours, mins, secs}, {5'd23, 6'd0, 6'd30});
      run = 1'b1;
      for (int i = 0; i < 8 && !sec_pulse; i++) step();
      check_value("s6_pulse_seen", sec_pulse, 32'd1);
      reset = 1'b1;
      #1;
      check_value("s6_async_reset", observed(), 32'd0);
      do_reset();
      check_value("s6_after_reset", observed(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
